// File: rtl/axi4_rd_burst_streamer.sv
// axi4_rd_burst_streamer
//
// AXI4 read master that fetches pkt_size_i bytes starting at addr_i (aligned
// down to the data-word size) and forwards the returned data as a single
// AXI4-Stream packet. Address and data channels run independently. Up to
// MAX_OUTSTANDING bursts may be in flight. Bursts are capped at
// MAX_BURST_LEN beats and never cross a 4 KB boundary.
//
// Optional feature macro: AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
//   When defined, adds err_o and the mem_rresp_i input. A non-OKAY response
//   sets err_o (sticky until the next accepted request) and marks that beat
//   with tuser[0]=1.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   pkt_size_i, addr_i      request size (bytes) and start byte address
//   rd_stb_i                start request, accepted only while busy_o=0
//   busy_o                  request in progress (includes the done_o cycle)
//   done_o                  one-cycle completion pulse
//   err_o                   sticky non-OKAY response flag (optional)
//   mem_ar*                 AXI4 read address channel (master side)
//   mem_r*                  AXI4 read data channel (master side)
//   mem_awvalid_o, mem_wvalid_o, mem_bready_o   write channel tie-offs
//   pkt_t*                  AXI4-Stream packet output

module axi4_rd_burst_streamer #(
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 1,
    parameter int ARUSER_WIDTH    = 1,
    parameter int TUSER_WIDTH     = 1,
    parameter int TDEST_WIDTH     = 1,
    parameter int MAX_BURST_LEN   = 256,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_PKT_SIZE_B  = 8192,
    parameter int SIZE_WIDTH      = $clog2(MAX_PKT_SIZE_B) + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [SIZE_WIDTH-1:0]     pkt_size_i,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic                      rd_stb_i,
    output logic                      busy_o,
    output logic                      done_o,
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
    output logic                      err_o,
`endif
    output logic                      mem_arvalid_o,
    input  logic                      mem_arready_i,
    output logic [ADDR_WIDTH-1:0]     mem_araddr_o,
    output logic [7:0]                mem_arlen_o,
    output logic [2:0]                mem_arsize_o,
    output logic [1:0]                mem_arburst_o,
    output logic [ID_WIDTH-1:0]       mem_arid_o,
    output logic                      mem_arlock_o,
    output logic [3:0]                mem_arcache_o,
    output logic [2:0]                mem_arprot_o,
    output logic [3:0]                mem_arqos_o,
    output logic [3:0]                mem_arregion_o,
    output logic [ARUSER_WIDTH-1:0]   mem_aruser_o,
    input  logic                      mem_rvalid_i,
    output logic                      mem_rready_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
    input  logic                      mem_rlast_i,
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
    input  logic [1:0]                mem_rresp_i,
`endif
    output logic                      mem_awvalid_o,
    output logic                      mem_wvalid_o,
    output logic                      mem_bready_o,
    output logic                      pkt_tvalid_o,
    input  logic                      pkt_tready_i,
    output logic [DATA_WIDTH-1:0]     pkt_tdata_o,
    output logic [DATA_WIDTH/8-1:0]   pkt_tkeep_o,
    output logic [DATA_WIDTH/8-1:0]   pkt_tstrb_o,
    output logic                      pkt_tlast_o,
    output logic [ID_WIDTH-1:0]       pkt_tid_o,
    output logic [TDEST_WIDTH-1:0]    pkt_tdest_o,
    output logic [TUSER_WIDTH-1:0]    pkt_tuser_o
);

    localparam int DW_B  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(DW_B);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int LEN_W = (SIZE_WIDTH > 14) ? SIZE_WIDTH : 14;
    localparam int SW1   = SIZE_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  nextAddr_q, nextAddr_d;
    logic [SIZE_WIDTH-1:0]  reqWordsLeft_q, reqWordsLeft_d;
    logic [SIZE_WIDTH-1:0]  dataWordsLeft_q, dataWordsLeft_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic                   arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
    logic [7:0]             arlen_q, arlen_d;
    logic [DW_B-1:0]        lastKeep_q, lastKeep_d;
    logic                   done_q, done_d;

    logic                   arHs;
    logic                   rHs;
    logic                   rLastHs;
    logic                   accept;
    logic [12:0]            bytesTo4k;
    logic [LEN_W-1:0]       wordsTo4k;
    logic [LEN_W-1:0]       burstLen;
    logic [SIZE_WIDTH-1:0]  sizeWords;
    logic [SIZE_WIDTH-1:0]  sizeRem;
    logic [DW_B-1:0]        lastKeepCalc;

    assign arHs    = arvalid_q & mem_arready_i;
    assign rHs     = mem_rvalid_i & pkt_tready_i;
    assign rLastHs = rHs & mem_rlast_i;
    assign busy_o  = (state_q != IDLE) || done_q;
    assign accept  = rd_stb_i && !busy_o;
    assign done_o  = done_q;

    // Word count is taken from the byte size alone; the alignment offset of
    // the start address does not add an extra word.
    assign sizeWords = SIZE_WIDTH'(({1'b0, pkt_size_i} + SW1'(DW_B - 1)) >> OFF_W);

    // Final-beat byte mask: the low (size mod DW_B) bytes, or every byte when
    // the size is an exact multiple of the word size.
    always_comb begin
        sizeRem = pkt_size_i & SIZE_WIDTH'(DW_B - 1);
        lastKeepCalc = '0;
        for (int b = 0; b < DW_B; b++) begin
            lastKeepCalc[b] = (sizeRem == '0) || (SIZE_WIDTH'(b) < sizeRem);
        end
    end

    // Next burst length: the smallest of the words still to request, the
    // burst cap, and the words remaining before the next 4 KB page.
    assign bytesTo4k = 13'h1000 - {1'b0, nextAddr_q[11:0]};
    assign wordsTo4k = LEN_W'(bytesTo4k >> OFF_W);

    always_comb begin
        burstLen = LEN_W'(reqWordsLeft_q);
        if (LEN_W'(MAX_BURST_LEN) < burstLen) begin
            burstLen = LEN_W'(MAX_BURST_LEN);
        end
        if (wordsTo4k < burstLen) begin
            burstLen = wordsTo4k;
        end
    end

    // State register and all datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            nextAddr_q      <= '0;
            reqWordsLeft_q  <= '0;
            dataWordsLeft_q <= '0;
            outstanding_q   <= '0;
            arvalid_q       <= 1'b0;
            araddr_q        <= '0;
            arlen_q         <= '0;
            lastKeep_q      <= '0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            nextAddr_q      <= nextAddr_d;
            reqWordsLeft_q  <= reqWordsLeft_d;
            dataWordsLeft_q <= dataWordsLeft_d;
            outstanding_q   <= outstanding_d;
            arvalid_q       <= arvalid_d;
            araddr_q        <= araddr_d;
            arlen_q         <= arlen_d;
            lastKeep_q      <= lastKeep_d;
            done_q          <= done_d;
        end
    end

    // Next-state logic. The AR register is preloaded: nextAddr/reqWordsLeft
    // advance when a burst is loaded into araddr/arlen, so that on a
    // handshake the following burst can be loaded in the same cycle.
    always_comb begin
        state_d         = state_q;
        nextAddr_d      = nextAddr_q;
        reqWordsLeft_d  = reqWordsLeft_q;
        dataWordsLeft_d = dataWordsLeft_q;
        outstanding_d   = outstanding_q;
        arvalid_d       = arvalid_q;
        araddr_d        = araddr_q;
        arlen_d         = arlen_q;
        lastKeep_d      = lastKeep_q;
        done_d          = 1'b0;

        if (arHs && !rLastHs) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!arHs && rLastHs && (outstanding_q != '0)) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end

        if (rHs && (dataWordsLeft_q != '0)) begin
            dataWordsLeft_d = dataWordsLeft_q - SIZE_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    nextAddr_d      = addr_i & ~ADDR_WIDTH'(DW_B - 1);
                    reqWordsLeft_d  = sizeWords;
                    dataWordsLeft_d = sizeWords;
                    lastKeep_d      = lastKeepCalc;
                    state_d         = (sizeWords == '0) ? DRAIN : ISSUE;
                end
            end

            ISSUE: begin
                if (arHs) begin
                    arvalid_d = 1'b0;
                end
                // Uses the post-update outstanding count so a burst is only
                // presented when it can be accepted without exceeding the limit.
                if ((!arvalid_q || mem_arready_i) && (reqWordsLeft_q != '0) &&
                    (outstanding_d < CNT_W'(MAX_OUTSTANDING))) begin
                    arvalid_d      = 1'b1;
                    araddr_d       = nextAddr_q;
                    arlen_d        = 8'(burstLen - LEN_W'(1));
                    nextAddr_d     = nextAddr_q + (ADDR_WIDTH'(burstLen) << OFF_W);
                    reqWordsLeft_d = reqWordsLeft_q - SIZE_WIDTH'(burstLen);
                end
                if (arHs && (reqWordsLeft_q == '0)) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                if ((dataWordsLeft_d == '0) && (outstanding_d == '0)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
    logic errBeat;
    logic err_q, err_d;

    assign errBeat = mem_rvalid_i && (mem_rresp_i != 2'b00);

    // Sticky error flag, cleared when a new request is accepted.
    always_comb begin
        err_d = err_q;
        if (accept && (state_q == IDLE)) begin
            err_d = 1'b0;
        end else if (rHs && errBeat) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o       = err_q;
    assign pkt_tuser_o = TUSER_WIDTH'(errBeat);
`else
    assign pkt_tuser_o = '0;
`endif

    assign mem_arvalid_o  = arvalid_q;
    assign mem_araddr_o   = araddr_q;
    assign mem_arlen_o    = arlen_q;
    assign mem_arsize_o   = 3'(OFF_W);
    assign mem_arburst_o  = 2'b01;
    assign mem_arid_o     = '0;
    assign mem_arlock_o   = 1'b0;
    assign mem_arcache_o  = 4'b0000;
    assign mem_arprot_o   = 3'b000;
    assign mem_arqos_o    = 4'b0000;
    assign mem_arregion_o = 4'b0000;
    assign mem_aruser_o   = '0;

    assign mem_awvalid_o  = 1'b0;
    assign mem_wvalid_o   = 1'b0;
    assign mem_bready_o   = 1'b1;

    // Zero-latency pass-through; tlast comes from our own word count so a
    // misbehaving rlast cannot end the packet early or late.
    assign mem_rready_o   = pkt_tready_i;
    assign pkt_tvalid_o   = mem_rvalid_i;
    assign pkt_tdata_o    = mem_rdata_i;
    assign pkt_tlast_o    = (dataWordsLeft_q == SIZE_WIDTH'(1));
    assign pkt_tkeep_o    = pkt_tlast_o ? lastKeep_q : '1;
    assign pkt_tstrb_o    = pkt_tkeep_o;
    assign pkt_tid_o      = '0;
    assign pkt_tdest_o    = '0;

endmodule

// File: tb/tb_axi4_rd_burst_streamer.sv
// tb_axi4_rd_burst_streamer
//
// Directed bench for axi4_rd_burst_streamer (64-bit data, 2 outstanding).
// A small memory model answers AR requests with data equal to {~addr, addr}.
// Expected AR requests and stream beats are pushed to queues when a request
// is issued and popped by the monitor as the DUT produces them.

module tb_axi4_rd_burst_streamer;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 32;
    localparam int SIZE_WIDTH = 14;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } arExp_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } memTxn_t;

    logic                   clk;
    logic                   rst;
    logic [SIZE_WIDTH-1:0]  pktSize;
    logic [ADDR_WIDTH-1:0]  startAddr;
    logic                   rdStb;
    logic                   busy;
    logic                   done;
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
    logic                   err;
    logic [1:0]             rresp;
`endif
    logic                   arvalid;
    logic                   arready;
    logic [31:0]            araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic [0:0]             arid;
    logic                   arlock;
    logic [3:0]             arcache;
    logic [2:0]             arprot;
    logic [3:0]             arqos;
    logic [3:0]             arregion;
    logic [0:0]             aruser;
    logic                   rvalid;
    logic                   rready;
    logic [63:0]            rdata;
    logic                   rlast;
    logic                   awvalid;
    logic                   wvalid;
    logic                   bready;
    logic                   tvalid;
    logic                   tready;
    logic [63:0]            tdata;
    logic [7:0]             tkeep;
    logic [7:0]             tstrb;
    logic                   tlast;
    logic [0:0]             tid;
    logic [0:0]             tdest;
    logic [0:0]             tuser;

    int      checks = 0;
    int      errors = 0;
    int      cycleNo = 0;
    int      doneCount = 0;
    int      doneCycle = 0;
    int      lastBeatCycle = 0;
    int      beatCount = 0;
    int      tlastCount = 0;
    int      arHsCount = 0;
    int      rlastCount = 0;
    int      arBeforeRlast = 0;
    int      arvalidSeen = 0;
    logic [7:0] lastKeepSeen;
    arExp_t  arLog[$];
    arExp_t  expArQ[$];
    beat_t   expBeatQ[$];

    logic    rEnable;
    logic    arStall;
    logic    tStall;

    axi4_rd_burst_streamer #(
        .DATA_WIDTH      (DATA_WIDTH),
        .ADDR_WIDTH      (ADDR_WIDTH),
        .ID_WIDTH        (1),
        .ARUSER_WIDTH    (1),
        .TUSER_WIDTH     (1),
        .TDEST_WIDTH     (1),
        .MAX_BURST_LEN   (256),
        .MAX_OUTSTANDING (2),
        .MAX_PKT_SIZE_B  (8192),
        .SIZE_WIDTH      (SIZE_WIDTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .pkt_size_i     (pktSize),
        .addr_i         (startAddr),
        .rd_stb_i       (rdStb),
        .busy_o         (busy),
        .done_o         (done),
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
        .err_o          (err),
`endif
        .mem_arvalid_o  (arvalid),
        .mem_arready_i  (arready),
        .mem_araddr_o   (araddr),
        .mem_arlen_o    (arlen),
        .mem_arsize_o   (arsize),
        .mem_arburst_o  (arburst),
        .mem_arid_o     (arid),
        .mem_arlock_o   (arlock),
        .mem_arcache_o  (arcache),
        .mem_arprot_o   (arprot),
        .mem_arqos_o    (arqos),
        .mem_arregion_o (arregion),
        .mem_aruser_o   (aruser),
        .mem_rvalid_i   (rvalid),
        .mem_rready_o   (rready),
        .mem_rdata_i    (rdata),
        .mem_rlast_i    (rlast),
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
        .mem_rresp_i    (rresp),
`endif
        .mem_awvalid_o  (awvalid),
        .mem_wvalid_o   (wvalid),
        .mem_bready_o   (bready),
        .pkt_tvalid_o   (tvalid),
        .pkt_tready_i   (tready),
        .pkt_tdata_o    (tdata),
        .pkt_tkeep_o    (tkeep),
        .pkt_tstrb_o    (tstrb),
        .pkt_tlast_o    (tlast),
        .pkt_tid_o      (tid),
        .pkt_tdest_o    (tdest),
        .pkt_tuser_o    (tuser)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck DUT can never hang the run.
    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time observed %0t, required finish before it", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Ready generators: fully ready unless the matching stall flag is set.
    always @(posedge clk) begin
        #1;
        arready = arStall ? ($urandom_range(0, 3) == 0) : 1'b1;
        tready  = tStall  ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    // Memory model: queues accepted ARs and replays them in order on R,
    // holding each beat until it is accepted.
    memTxn_t memArQ[$];
    logic    rBusy = 1'b0;
    logic [31:0] rAddr;
    int      rBeat;
    int      rLen;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            memArQ.delete();
            rBusy = 1'b0;
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            rdata  <= '0;
        end else begin
            if (arvalid && arready) begin
                memArQ.push_back('{araddr, int'(arlen)});
            end
            if (rvalid && rready) begin
                if (rlast) begin
                    rBusy = 1'b0;
                end else begin
                    rBeat++;
                    rAddr += 32'd8;
                end
            end
            if (!rBusy && (memArQ.size() > 0)) begin
                rAddr = memArQ[0].addr;
                rLen  = memArQ[0].len;
                rBeat = 0;
                rBusy = 1'b1;
                void'(memArQ.pop_front());
            end
            if (rBusy && rEnable) begin
                rvalid <= 1'b1;
                rdata  <= {~rAddr, rAddr};
                rlast  <= (rBeat == rLen);
            end else begin
                rvalid <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Monitor: samples on the falling edge, so every observed handshake is
    // the one that completes on the following rising edge.
    logic   prevArStall = 1'b0;
    arExp_t prevAr;

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                doneCount++;
                doneCycle = cycleNo;
            end
            if (arvalid) begin
                arvalidSeen++;
            end
            if (arvalid && prevArStall) begin
                checkOutput("arStable", {araddr, arlen}, prevAr);
            end
            prevArStall = arvalid && !arready;
            prevAr      = '{araddr, arlen};
            if (arvalid && arready) begin
                arHsCount++;
                if (rlastCount == 0) begin
                    arBeforeRlast++;
                end
                arLog.push_back('{araddr, arlen});
                checkOutput("arExpected", expArQ.size() > 0, 1);
                if (expArQ.size() > 0) begin
                    checkOutput("arAddrLen", {araddr, arlen}, expArQ.pop_front());
                end
            end
            if (tvalid && tready) begin
                beat_t e;
                beatCount++;
                if (rlast) begin
                    rlastCount++;
                end
                if (tlast) begin
                    tlastCount++;
                    lastBeatCycle = cycleNo;
                    lastKeepSeen  = tkeep;
                end
                checkOutput("beatExpected", expBeatQ.size() > 0, 1);
                if (expBeatQ.size() > 0) begin
                    e = expBeatQ.pop_front();
                    checkOutput("beat", {tdata, tkeep, tstrb, tlast, tuser},
                                {e.data, e.keep, e.keep, e.last, 1'b0});
                end
            end
        end
        cycleNo++;
    end

    // Reference model: expected ARs and beats for one request.
    task automatic pushModel(input logic [31:0] addr, input int size);
        logic [31:0] a;
        int words;
        int rem;
        int left;
        int len;
        int toB;
        a     = addr & 32'hFFFF_FFF8;
        words = (size + 7) / 8;
        rem   = size % 8;
        for (int i = 0; i < words; i++) begin
            beat_t b;
            b.data = {~(a + 32'(i * 8)), a + 32'(i * 8)};
            b.keep = ((i == words - 1) && (rem != 0)) ? 8'((1 << rem) - 1) : 8'hFF;
            b.last = (i == words - 1);
            expBeatQ.push_back(b);
        end
        left = words;
        while (left > 0) begin
            toB = (4096 - int'(a[11:0])) / 8;
            len = left;
            if (len > 256) len = 256;
            if (len > toB) len = toB;
            expArQ.push_back('{a, 8'(len - 1)});
            a    += 32'(len * 8);
            left -= len;
        end
    endtask

    // Called at a falling edge; pulses rd_stb_i for one cycle.
    task automatic applyStimulus(input logic [31:0] addr, input int size, input bit expectAccept);
        if (expectAccept) begin
            for (int g = 0; g < 2000 && busy; g++) @(negedge clk);
            pushModel(addr, size);
        end
        startAddr = addr;
        pktSize   = SIZE_WIDTH'(size);
        rdStb     = 1'b1;
        @(negedge clk);
        rdStb     = 1'b0;
        if (expectAccept) begin
            checkOutput("busyAfterAccept", busy, 1);
        end
    endtask

    task automatic waitDone(input string tag, input int budget);
        int start;
        start = doneCount;
        for (int i = 0; i < budget && doneCount == start; i++) @(negedge clk);
        checkOutput({tag, "_done"}, doneCount > start, 1);
        checkOutput({tag, "_arLeft"}, expArQ.size(), 0);
        checkOutput({tag, "_beatsLeft"}, expBeatQ.size(), 0);
    endtask

    task automatic clearLogs();
        arLog.delete();
        beatCount     = 0;
        tlastCount    = 0;
        arHsCount     = 0;
        rlastCount    = 0;
        arBeforeRlast = 0;
    endtask

    initial begin
        rst       = 1'b1;
        rdStb     = 1'b0;
        pktSize   = '0;
        startAddr = '0;
        rEnable   = 1'b1;
        arStall   = 1'b0;
        tStall    = 1'b0;
        arready   = 1'b1;
        tready    = 1'b1;
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
        rresp     = 2'b00;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_arvalid", arvalid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_araddr", araddr, 0);
        checkOutput("rst_arlen", arlen, 0);
        checkOutput("tieoffs", {awvalid, wvalid, bready, arsize, arburst}, {1'b0, 1'b0, 1'b1, 3'd3, 2'b01});
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single 8-beat burst, plus a request while busy");
        clearLogs();
        applyStimulus(32'h1000, 64, 1'b1);
        applyStimulus(32'h5000, 64, 1'b0);
        waitDone("t1", 200);
        checkOutput("t1_arCount", arLog.size(), 1);
        checkOutput("t1_ar0", arLog[0], {32'h1000, 8'd7});
        checkOutput("t1_beats", beatCount, 8);
        checkOutput("t1_keep", lastKeepSeen, 8'hFF);
        checkOutput("t1_doneLatency", doneCycle - lastBeatCycle, 1);

        $display("[TB] 4100 bytes from 0x0");
        clearLogs();
        applyStimulus(32'h0, 4100, 1'b1);
        waitDone("t2", 2000);
        checkOutput("t2_arCount", arLog.size(), 3);
        checkOutput("t2_ar1", arLog[1], {32'h800, 8'd255});
        checkOutput("t2_ar2", arLog[2], {32'h1000, 8'd0});
        checkOutput("t2_beats", beatCount, 513);
        checkOutput("t2_keep", lastKeepSeen, 8'h0F);

        $display("[TB] 4 KB crossing");
        clearLogs();
        applyStimulus(32'h0FC0, 128, 1'b1);
        waitDone("t3", 300);
        checkOutput("t3_ar0", arLog[0], {32'h0FC0, 8'd7});
        checkOutput("t3_ar1", arLog[1], {32'h1000, 8'd7});
        checkOutput("t3_beats", beatCount, 16);
        checkOutput("t3_tlasts", tlastCount, 1);

        $display("[TB] request in the done cycle is ignored");
        clearLogs();
        applyStimulus(32'h100, 16, 1'b1);
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        checkOutput("t3b_doneSeen", done, 1);
        applyStimulus(32'h200, 8, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("t3b_arCount", arLog.size(), 1);
        checkOutput("t3b_busy", busy, 0);

        $display("[TB] outstanding limit with R held off");
        clearLogs();
        rEnable = 1'b0;
        applyStimulus(32'h0, 8192, 1'b1);
        repeat (30) @(negedge clk);
        checkOutput("t4_arHeld", arHsCount, 2);
        checkOutput("t4_arvalidLow", arvalid, 0);
        checkOutput("t4_noBeats", beatCount, 0);
        rEnable = 1'b1;
        waitDone("t4", 3000);
        checkOutput("t4_arBeforeRlast", arBeforeRlast, 2);
        checkOutput("t4_beats", beatCount, 1024);

        $display("[TB] random stalls, unaligned start");
        clearLogs();
        arStall = 1'b1;
        tStall  = 1'b1;
        applyStimulus(32'h0333, 1000, 1'b1);
        waitDone("t5", 3000);
        arStall = 1'b0;
        tStall  = 1'b0;
        checkOutput("t5_ar0Addr", arLog[0].addr, 32'h330);
        checkOutput("t5_beats", beatCount, 125);
        checkOutput("t5_keep", lastKeepSeen, 8'hFF);
        checkOutput("t5_tlasts", tlastCount, 1);

        $display("[TB] zero-size request");
        clearLogs();
        begin
            int seen0;
            @(negedge clk);
            seen0 = arvalidSeen;
            applyStimulus(32'h400, 0, 1'b1);
            waitDone("t6a", 20);
            checkOutput("t6a_noArvalid", arvalidSeen - seen0, 0);
            checkOutput("t6a_beats", beatCount, 0);
        end

        $display("[TB] reset mid-burst, then a normal request");
        clearLogs();
        applyStimulus(32'h2000, 2048, 1'b1);
        for (int i = 0; i < 500 && beatCount < 10; i++) @(negedge clk);
        checkOutput("t6b_midBurst", beatCount >= 10, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6b_rstArvalid", arvalid, 0);
        checkOutput("t6b_rstBusy", busy, 0);
        checkOutput("t6b_rstTvalid", tvalid, 0);
        checkOutput("t6b_rstTlast", tlast, 0);
        expArQ.delete();
        expBeatQ.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clearLogs();
        applyStimulus(32'h40, 24, 1'b1);
        waitDone("t6c", 100);
        checkOutput("t6c_ar0", arLog[0], {32'h40, 8'd2});
        checkOutput("t6c_beats", beatCount, 3);
`ifdef AXI4_RD_BURST_STREAMER_RRESP_ERR_EN
        checkOutput("errClear", err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
